// File: rtl/pic_priority_resolver.sv
`default_nettype none
// ============================================================================
// Module   : pic_priority_resolver
// Purpose  : 8259-style interrupt priority resolver and in-service tracker.
//            Picks the highest-priority unmasked request and raises int_out.
//            Runs the INTA pulse sequence and maintains the in-service
//            register (set on acknowledge, cleared by EOI/AEOI, with
//            optional priority rotation).
// Ports    : clk, rst_n        - clock, async active-low reset
//            init             - ICW1 strobe, synchronous soft reset
//            irr, imr         - latched requests and mask (1 = masked)
//            inta_n           - CPU acknowledge, active low, clk-synchronous
//            aeoi             - automatic EOI enable
//            eoi, eoi_specific, eoi_rotate, eoi_level - OCW2 EOI command
//            int_out          - interrupt request to CPU
//            irr_clr          - one-hot pulse clearing the acknowledged IRR bit
//            isr              - in-service register
//            level            - frozen resolved level for the cascade stage
//            level_valid      - high for the whole acknowledge sequence
//            spurious         - acknowledge found no eligible request
// Revision : 1.0 - initial release
// ============================================================================
module pic_priority_resolver #(
  // Legal values are 2 (8086 mode) and 3 (8080 mode); the counter is 2 bits.
  parameter int         INTA_PULSES    = 2,
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta_n,
  input  logic       aeoi,
  input  logic       eoi,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] irr_clr,
  output logic [7:0] isr,
  output logic [2:0] level,
  output logic       level_valid,
  output logic       spurious
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam logic [1:0] PULSES = 2'(INTA_PULSES);

  // Returns {found, level} of the highest-priority set bit of v, where
  // (ptr + 1) mod 8 is highest and ptr itself is lowest.
  function automatic logic [3:0] find_top(input logic [7:0] v, input logic [2:0] ptr);
    logic [2:0] idx;
    find_top = 4'b0000;
    // Scan lowest to highest priority so the last hit wins.
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'd1 + 3'(i);
      if (v[idx]) find_top = {1'b1, idx};
    end
  endfunction

  // Priority rank of level l: 0 = highest.
  function automatic logic [2:0] rank(input logic [2:0] l, input logic [2:0] ptr);
    rank = l - ptr - 3'd1;
  endfunction

  // Registered state
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] level_q, level_d;
  logic       lv_q, lv_d;
  logic       sp_q, sp_d;
  logic       int_q, int_d;
  logic [7:0] irr_clr_q, irr_clr_d;
  logic       inta_prev_q;

  // Combinational intermediates
  logic [7:0] isr_eoi;
  logic [2:0] ptr_eoi;
  logic [3:0] isr_top;
  logic [3:0] cand;
  logic [3:0] blk;
  logic       eligible;
  logic       fall;
  logic       rise;

  always_comb begin
    // EOI is applied first so that a simultaneous acknowledge resolves
    // against the post-EOI ISR and pointer.
    isr_eoi = isr_q;
    ptr_eoi = ptr_q;
    isr_top = find_top(isr_q, ptr_q);
    if (eoi) begin
      if (eoi_specific) begin
        isr_eoi[eoi_level] = 1'b0;
        if (eoi_rotate) ptr_eoi = eoi_level;
      end else if (isr_top[3]) begin
        isr_eoi[isr_top[2:0]] = 1'b0;
        if (eoi_rotate) ptr_eoi = isr_top[2:0];
      end
    end

    cand = find_top(irr & ~imr, ptr_eoi);
    blk  = find_top(isr_eoi, ptr_eoi);
    // An in-service level of equal or higher priority blocks the candidate.
    eligible = cand[3] &&
               (!blk[3] || (rank(cand[2:0], ptr_eoi) < rank(blk[2:0], ptr_eoi)));

    fall = inta_prev_q & ~inta_n;
    rise = ~inta_prev_q & inta_n;

    state_d   = state_q;
    cnt_d     = cnt_q;
    isr_d     = isr_eoi;
    ptr_d     = ptr_eoi;
    level_d   = level_q;
    lv_d      = lv_q;
    sp_d      = sp_q;
    irr_clr_d = 8'h00;
    int_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = ACK;
          cnt_d   = 2'd1;
          lv_d    = 1'b1;
          if (eligible) begin
            level_d             = cand[2:0];
            isr_d[cand[2:0]]    = 1'b1;
            irr_clr_d[cand[2:0]] = 1'b1;
            sp_d                = 1'b0;
          end else begin
            level_d = SPURIOUS_LEVEL;
            sp_d    = 1'b1;
          end
        end else begin
          int_d = eligible;
        end
      end
      ACK: begin
        // Falls beyond the configured pulse count are ignored.
        if (fall && (cnt_q < PULSES)) begin
          cnt_d = cnt_q + 2'd1;
        end else if (rise && (cnt_q == PULSES)) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
          lv_d    = 1'b0;
          sp_d    = 1'b0;
          if (aeoi && !sp_q) begin
            isr_d[level_q] = 1'b0;
            if (eoi_rotate) ptr_d = level_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      ptr_q       <= 3'd7;
      isr_q       <= 8'h00;
      level_q     <= 3'd0;
      lv_q        <= 1'b0;
      sp_q        <= 1'b0;
      int_q       <= 1'b0;
      irr_clr_q   <= 8'h00;
      inta_prev_q <= 1'b1;
    end else if (init) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      ptr_q       <= 3'd7;
      isr_q       <= 8'h00;
      level_q     <= 3'd0;
      lv_q        <= 1'b0;
      sp_q        <= 1'b0;
      int_q       <= 1'b0;
      irr_clr_q   <= 8'h00;
      inta_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      isr_q       <= isr_d;
      level_q     <= level_d;
      lv_q        <= lv_d;
      sp_q        <= sp_d;
      int_q       <= int_d;
      irr_clr_q   <= irr_clr_d;
      inta_prev_q <= inta_n;
    end
  end

  assign int_out     = int_q;
  assign irr_clr     = irr_clr_q;
  assign isr         = isr_q;
  assign level       = level_q;
  assign level_valid = lv_q;
  assign spurious    = sp_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_priority_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_priority_resolver
// Purpose  : Directed self-checking bench for pic_priority_resolver. One
//            instance uses 2 INTA pulses, a second uses 3 pulses with its
//            own INTA line and shares all other inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_priority_resolver;

  logic       clk;
  logic       rst_n;
  logic       init;
  logic [7:0] irr;
  logic [7:0] imr;
  logic       inta_n;
  logic       inta_n3;
  logic       aeoi;
  logic       eoi;
  logic       eoi_specific;
  logic       eoi_rotate;
  logic [2:0] eoi_level;

  logic       int_out,  int_out3;
  logic [7:0] irr_clr,  irr_clr3;
  logic [7:0] isr,      isr3;
  logic [2:0] level,    level3;
  logic       level_valid, level_valid3;
  logic       spurious, spurious3;

  int vectors    = 0;
  int miscompares = 0;

  pic_priority_resolver #(.INTA_PULSES(2), .SPURIOUS_LEVEL(3'd7)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .irr(irr), .imr(imr),
    .inta_n(inta_n), .aeoi(aeoi), .eoi(eoi), .eoi_specific(eoi_specific),
    .eoi_rotate(eoi_rotate), .eoi_level(eoi_level),
    .int_out(int_out), .irr_clr(irr_clr), .isr(isr), .level(level),
    .level_valid(level_valid), .spurious(spurious)
  );

  pic_priority_resolver #(.INTA_PULSES(3), .SPURIOUS_LEVEL(3'd7)) dut3 (
    .clk(clk), .rst_n(rst_n), .init(init), .irr(irr), .imr(imr),
    .inta_n(inta_n3), .aeoi(aeoi), .eoi(eoi), .eoi_specific(eoi_specific),
    .eoi_rotate(eoi_rotate), .eoi_level(eoi_level),
    .int_out(int_out3), .irr_clr(irr_clr3), .isr(isr3), .level(level3),
    .level_valid(level_valid3), .spurious(spurious3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inta_fall();
    inta_n = 1'b0;
    tick();
  endtask

  // Completes a 2-pulse sequence after inta_fall().
  task automatic inta_finish();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b0; irr = 8'h00; imr = 8'h00;
    inta_n = 1'b1; inta_n3 = 1'b1; aeoi = 1'b0; eoi = 1'b0;
    eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = 3'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_int", {7'd0, int_out}, 8'h00);
    chk("rst_irr_clr", irr_clr, 8'h00);
    chk("rst_isr", isr, 8'h00);
    chk("rst_level", {5'd0, level}, 8'h00);
    chk("rst_valid", {7'd0, level_valid}, 8'h00);
    chk("rst_spur", {7'd0, spurious}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // AEOI with 3 INTA pulses on IR7
    aeoi = 1'b1; irr = 8'h80;
    tick();
    chk("p3_int", {7'd0, int_out3}, 8'h01);
    inta_n3 = 1'b0; tick();
    chk("p3_valid1", {7'd0, level_valid3}, 8'h01);
    chk("p3_level", {5'd0, level3}, 8'h07);
    chk("p3_isr1", isr3, 8'h80);
    irr = 8'h00;
    inta_n3 = 1'b1; tick();
    inta_n3 = 1'b0; tick();
    inta_n3 = 1'b1; tick();
    chk("p3_valid2", {7'd0, level_valid3}, 8'h01);
    chk("p3_isr2", isr3, 8'h80);
    inta_n3 = 1'b0; tick();
    chk("p3_valid3", {7'd0, level_valid3}, 8'h01);
    inta_n3 = 1'b1; tick();
    chk("p3_valid_end", {7'd0, level_valid3}, 8'h00);
    chk("p3_isr_end", isr3, 8'h00);
    aeoi = 1'b0;
    tick();

    // Basic acknowledge of IR2 out of {IR2, IR4}
    irr = 8'h14;
    tick();
    chk("t1_int", {7'd0, int_out}, 8'h01);
    inta_fall();
    chk("t1_level", {5'd0, level}, 8'h02);
    chk("t1_valid", {7'd0, level_valid}, 8'h01);
    chk("t1_isr", isr, 8'h04);
    chk("t1_irr_clr", irr_clr, 8'h04);
    chk("t1_int_ack", {7'd0, int_out}, 8'h00);
    irr = 8'h10;
    tick();
    chk("t1_irr_clr_off", irr_clr, 8'h00);
    inta_finish();
    chk("t1_valid_end", {7'd0, level_valid}, 8'h00);
    chk("t1_isr_held", isr, 8'h04);
    tick();
    chk("t1_ir4_blocked", {7'd0, int_out}, 8'h00);
    eoi = 1'b1; eoi_specific = 1'b0;
    tick();
    eoi = 1'b0;
    chk("t1_isr_eoi", isr, 8'h00);
    chk("t1_ir4_int", {7'd0, int_out}, 8'h01);
    irr = 8'h00;
    tick(); tick();

    // Nesting: IR2 in service blocks IR3/IR5, IR1 preempts
    irr = 8'h04;
    tick();
    inta_fall();
    irr = 8'h00;
    inta_finish();
    chk("t2_isr", isr, 8'h04);
    irr = 8'h28;
    tick(); tick();
    chk("t2_blocked", {7'd0, int_out}, 8'h00);
    irr = 8'h02;
    tick();
    chk("t2_int", {7'd0, int_out}, 8'h01);
    inta_fall();
    chk("t2_level", {5'd0, level}, 8'h01);
    chk("t2_isr_nest", isr, 8'h06);
    irr = 8'h00;
    inta_finish();
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("t2_eoi1", isr, 8'h04);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("t2_eoi2", isr, 8'h00);

    // Specific EOI with rotate at level 4: IR5 becomes highest
    eoi = 1'b1; eoi_specific = 1'b1; eoi_rotate = 1'b1; eoi_level = 3'd4;
    tick();
    eoi = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0;
    irr = 8'h21;
    tick();
    chk("t4_int", {7'd0, int_out}, 8'h01);
    inta_fall();
    chk("t4_level", {5'd0, level}, 8'h05);
    chk("t4_isr", isr, 8'h20);
    irr = 8'h01;
    inta_finish();
    tick();
    chk("t4_ir0_blocked", {7'd0, int_out}, 8'h00);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("t4_eoi", isr, 8'h00);
    chk("t4_ir0_int", {7'd0, int_out}, 8'h01);
    inta_fall();
    chk("t4_level0", {5'd0, level}, 8'h00);
    irr = 8'h00;
    inta_finish();
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("t4_isr_end", isr, 8'h00);

    // Request withdrawn before INTA -> spurious
    irr = 8'h08;
    tick();
    chk("t5_int", {7'd0, int_out}, 8'h01);
    irr = 8'h00;
    tick();
    inta_fall();
    chk("t5_level", {5'd0, level}, 8'h07);
    chk("t5_spur", {7'd0, spurious}, 8'h01);
    chk("t5_isr", isr, 8'h00);
    chk("t5_irr_clr", irr_clr, 8'h00);
    inta_finish();
    chk("t5_spur_end", {7'd0, spurious}, 8'h00);
    chk("t5_valid_end", {7'd0, level_valid}, 8'h00);

    // Asynchronous reset mid-sequence
    irr = 8'h04;
    tick();
    inta_fall();
    chk("t6_valid", {7'd0, level_valid}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {7'd0, level_valid}, 8'h00);
    chk("t6_rst_level", {5'd0, level}, 8'h00);
    chk("t6_rst_isr", isr, 8'h00);
    chk("t6_rst_int", {7'd0, int_out}, 8'h00);
    inta_n = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("t6_int", {7'd0, int_out}, 8'h01);
    inta_fall();
    chk("t6_level", {5'd0, level}, 8'h02);
    chk("t6_isr", isr, 8'h04);
    irr = 8'h00;
    inta_finish();
    chk("t6_valid_end", {7'd0, level_valid}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
